// File: rtl/trap_csr_sequencer_if.sv
// Bus bundle between the execute stage / CSR stack and trap_csr_sequencer.
// master: the side that issues instructions and CSR requests and consumes the write port.
// slave:  the sequencer itself.
interface trap_csr_sequencer_if #(
  parameter int XLEN = 32
);
  logic            ex_valid;
  logic            ex_ecall;
  logic            ex_mret;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] mtvec_in;
  logic [XLEN-1:0] mepc_in;
  logic [XLEN-1:0] mstatus_in;
  logic            csr_req;
  logic [3:0]      csr_req_wen;
  logic [XLEN-1:0] csr_req_data;
  logic            csr_gnt;
  logic [3:0]      csr_wen;
  logic [XLEN-1:0] csrd;
  logic            stall;
  logic            redirect_vld;
  logic [XLEN-1:0] redirect_pc;
  logic            busy;

  modport master (
    output ex_valid, ex_ecall, ex_mret, ex_pc,
    output mtvec_in, mepc_in, mstatus_in,
    output csr_req, csr_req_wen, csr_req_data,
    input  csr_gnt, csr_wen, csrd, stall, redirect_vld, redirect_pc, busy
  );

  modport slave (
    input  ex_valid, ex_ecall, ex_mret, ex_pc,
    input  mtvec_in, mepc_in, mstatus_in,
    input  csr_req, csr_req_wen, csr_req_data,
    output csr_gnt, csr_wen, csrd, stall, redirect_vld, redirect_pc, busy
  );
endinterface

// File: rtl/trap_csr_sequencer.sv
// Machine-mode trap sequencer sharing the single CSR write port with CSR instructions.
// ecall: write mepc, mcause, mstatus, then redirect to mtvec. mret: write mstatus,
// then redirect to mepc. Trap entry/return always wins over a CSR instruction request.
// Optional feature: define TRAP_COUNT_EN to add the saturating trap_count output.
module trap_csr_sequencer #(
  parameter int XLEN        = 32,
  parameter int ECALL_CAUSE = 11
) (
  input  logic                 clock,
  input  logic                 reset,   // asynchronous, active-low
  trap_csr_sequencer_if.slave  bus
`ifdef TRAP_COUNT_EN
  ,
  output logic [31:0]          trap_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_T_EPC   = 3'd1,
    S_T_CAUSE = 3'd2,
    S_T_STAT  = 3'd3,
    S_R_STAT  = 3'd4,
    S_REDIR   = 3'd5
  } state_e;

  // mstatus image written on trap entry: MPIE<=MIE, MIE<=0, MPP<=M
  function automatic logic [XLEN-1:0] ecall_mstatus(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r        = s;
    r[7]     = s[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // mstatus image written on mret: MIE<=MPIE, MPIE<=1, MPP<=M
  function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r        = s;
    r[3]     = s[7];
    r[7]     = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction

  localparam logic [XLEN-1:0] MTVEC_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] mstat_q, mstat_d;
  logic            is_mret_q, is_mret_d;
  logic            ecall_req_s;
  logic            trap_req_s;

  assign ecall_req_s = bus.ex_valid & bus.ex_ecall;
  assign trap_req_s  = bus.ex_valid & (bus.ex_ecall | bus.ex_mret);

  // State and latched trap context registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      pc_q      <= {XLEN{1'b0}};
      mstat_q   <= {XLEN{1'b0}};
      is_mret_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      mstat_q   <= mstat_d;
      is_mret_q <= is_mret_d;
    end
  end

  // Next-state and context capture; new instructions are only accepted in IDLE
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    mstat_d   = mstat_q;
    is_mret_d = is_mret_q;
    case (state_q)
      S_IDLE: begin
        if (ecall_req_s) begin
          state_d   = S_T_EPC;
          pc_d      = bus.ex_pc;
          mstat_d   = bus.mstatus_in;
          is_mret_d = 1'b0;
        end else if (trap_req_s) begin
          state_d   = S_R_STAT;
          mstat_d   = bus.mstatus_in;
          is_mret_d = 1'b1;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_T_EPC:   state_d = S_T_CAUSE;
      S_T_CAUSE: state_d = S_T_STAT;
      S_T_STAT:  state_d = S_REDIR;
      S_R_STAT:  state_d = S_REDIR;
      S_REDIR:   state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output decode: Moore from state, except the IDLE accept-cycle stall and grant path.
  // The IDLE path is gated by reset so every output reads 0 while reset is held.
  always_comb begin
    bus.csr_gnt      = 1'b0;
    bus.csr_wen      = 4'b0000;
    bus.csrd         = {XLEN{1'b0}};
    bus.stall        = 1'b0;
    bus.redirect_vld = 1'b0;
    bus.redirect_pc  = {XLEN{1'b0}};
    bus.busy         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (reset && trap_req_s) begin
          bus.stall = 1'b1;
        end else begin
          bus.stall = 1'b0;
        end
        if (reset && bus.csr_req && !trap_req_s) begin
          bus.csr_gnt = 1'b1;
          bus.csr_wen = bus.csr_req_wen;
          bus.csrd    = bus.csr_req_data;
        end else begin
          bus.csr_gnt = 1'b0;
          bus.csr_wen = 4'b0000;
          bus.csrd    = {XLEN{1'b0}};
        end
      end
      S_T_EPC: begin
        bus.stall   = 1'b1;
        bus.busy    = 1'b1;
        bus.csr_wen = 4'b0001;
        bus.csrd    = pc_q;
      end
      S_T_CAUSE: begin
        bus.stall   = 1'b1;
        bus.busy    = 1'b1;
        bus.csr_wen = 4'b0010;
        bus.csrd    = XLEN'(ECALL_CAUSE);
      end
      S_T_STAT: begin
        bus.stall   = 1'b1;
        bus.busy    = 1'b1;
        bus.csr_wen = 4'b0100;
        bus.csrd    = ecall_mstatus(mstat_q);
      end
      S_R_STAT: begin
        bus.stall   = 1'b1;
        bus.busy    = 1'b1;
        bus.csr_wen = 4'b0100;
        bus.csrd    = mret_mstatus(mstat_q);
      end
      S_REDIR: begin
        bus.stall        = 1'b1;
        bus.busy         = 1'b1;
        bus.redirect_vld = 1'b1;
        // mepc is sampled here, so an mret sees any mepc write that came before it
        if (is_mret_q) begin
          bus.redirect_pc = bus.mepc_in;
        end else begin
          bus.redirect_pc = bus.mtvec_in & MTVEC_MASK;
        end
      end
      default: begin
        bus.busy = 1'b0;
      end
    endcase
  end

`ifdef TRAP_COUNT_EN
  logic [31:0] count_q, count_d;

  // Saturating count of completed ecall sequences
  always_comb begin
    count_d = count_q;
    if ((state_q == S_REDIR) && !is_mret_q && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Trap counter register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= 32'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign trap_count = count_q;
`endif

endmodule

// File: tb/tb_trap_csr_sequencer.sv
// Directed, table-driven bench for trap_csr_sequencer.
module tb_trap_csr_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  trap_csr_sequencer_if #(.XLEN(32)) bus();
`ifdef TRAP_COUNT_EN
  logic [31:0] trap_count;
`endif

  trap_csr_sequencer #(.XLEN(32), .ECALL_CAUSE(11)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef TRAP_COUNT_EN
    ,
    .trap_count (trap_count)
`endif
  );

  typedef struct packed {
    logic        ev, ec, mr;
    logic [31:0] pc, mtvec, mepc, mst;
    logic        rq;
    logic [3:0]  rwen;
    logic [31:0] rdata;
    logic        gnt;
    logic [3:0]  wen;
    logic [31:0] csrd;
    logic        stall, rv;
    logic [31:0] rpc;
    logic        busy;
  } vec_t;

  int   n_tests = 0;
  int   n_fails = 0;
  vec_t tbl[$];

  function automatic vec_t mk(
    input logic ev, ec, mr, input logic [31:0] pc, mtvec, mepc, mst,
    input logic rq, input logic [3:0] rwen, input logic [31:0] rdata,
    input logic gnt, input logic [3:0] wen, input logic [31:0] csrd,
    input logic stall, rv, input logic [31:0] rpc, input logic busy);
    vec_t v;
    v.ev = ev; v.ec = ec; v.mr = mr; v.pc = pc; v.mtvec = mtvec; v.mepc = mepc;
    v.mst = mst; v.rq = rq; v.rwen = rwen; v.rdata = rdata; v.gnt = gnt; v.wen = wen;
    v.csrd = csrd; v.stall = stall; v.rv = rv; v.rpc = rpc; v.busy = busy;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.ex_valid     = v.ev;
    bus.ex_ecall     = v.ec;
    bus.ex_mret      = v.mr;
    bus.ex_pc        = v.pc;
    bus.mtvec_in     = v.mtvec;
    bus.mepc_in      = v.mepc;
    bus.mstatus_in   = v.mst;
    bus.csr_req      = v.rq;
    bus.csr_req_wen  = v.rwen;
    bus.csr_req_data = v.rdata;
  endtask

  // Apply one record at the negedge and compare mid-cycle, before the next rising edge
  task automatic run_vec(input int idx, input vec_t v);
    @(negedge clock);
    drive(v);
    #1;
    chk("gnt",   idx, {31'd0, bus.csr_gnt},      {31'd0, v.gnt});
    chk("wen",   idx, {28'd0, bus.csr_wen},      {28'd0, v.wen});
    chk("csrd",  idx, bus.csrd,                  v.csrd);
    chk("stall", idx, {31'd0, bus.stall},        {31'd0, v.stall});
    chk("rvld",  idx, {31'd0, bus.redirect_vld}, {31'd0, v.rv});
    chk("rpc",   idx, bus.redirect_pc,           v.rpc);
    chk("busy",  idx, {31'd0, bus.busy},         {31'd0, v.busy});
  endtask

  task automatic chk_quiet(input string nm, input int idx);
    chk({nm, "_gnt"},   idx, {31'd0, bus.csr_gnt},      32'd0);
    chk({nm, "_wen"},   idx, {28'd0, bus.csr_wen},      32'd0);
    chk({nm, "_csrd"},  idx, bus.csrd,                  32'd0);
    chk({nm, "_stall"}, idx, {31'd0, bus.stall},        32'd0);
    chk({nm, "_rvld"},  idx, {31'd0, bus.redirect_vld}, 32'd0);
    chk({nm, "_rpc"},   idx, bus.redirect_pc,           32'd0);
    chk({nm, "_busy"},  idx, {31'd0, bus.busy},         32'd0);
  endtask

  initial begin
    vec_t idle_v;
    idle_v = mk(0,0,0, 0,0,0,0, 0,4'h0,0, 0,4'h0,0, 0,0,0,0);

    //            ev ec mr  pc       mtvec     mepc     mst       rq rwen  rdata       gnt wen   csrd      st rv rpc     busy
    // ecall: mepc<=0x100, mcause<=11, mstatus<=0x1880, redirect 0x200
    tbl.push_back(mk(1,1,0, 32'h100, 32'h201, 32'h0,   32'h8,    0,4'h0,32'h0,       0,4'h0,32'h0,    1,0,32'h0,  0));
    tbl.push_back(mk(0,0,0, 32'h0,   32'h201, 32'h0,   32'h0,    0,4'h0,32'h0,       0,4'h1,32'h100,  1,0,32'h0,  1));
    tbl.push_back(mk(0,0,0, 32'h0,   32'h201, 32'h0,   32'h0,    0,4'h0,32'h0,       0,4'h2,32'd11,   1,0,32'h0,  1));
    tbl.push_back(mk(0,0,0, 32'h0,   32'h201, 32'h0,   32'h0,    0,4'h0,32'h0,       0,4'h4,32'h1880, 1,0,32'h0,  1));
    tbl.push_back(mk(0,0,0, 32'h0,   32'h201, 32'h0,   32'h0,    0,4'h0,32'h0,       0,4'h0,32'h0,    1,1,32'h200,1));
    tbl.push_back(mk(0,0,0, 32'h0,   32'h201, 32'h0,   32'h0,    0,4'h0,32'h0,       0,4'h0,32'h0,    0,0,32'h0,  0));
    // mret: mstatus 0x1880 -> 0x1888, redirect to mepc 0x104
    tbl.push_back(mk(1,0,1, 32'h0,   32'h0,   32'h104, 32'h1880, 0,4'h0,32'h0,       0,4'h0,32'h0,    1,0,32'h0,  0));
    tbl.push_back(mk(0,0,0, 32'h0,   32'h0,   32'h104, 32'h0,    0,4'h0,32'h0,       0,4'h4,32'h1888, 1,0,32'h0,  1));
    tbl.push_back(mk(0,0,0, 32'h0,   32'h0,   32'h104, 32'h0,    0,4'h0,32'h0,       0,4'h0,32'h0,    1,1,32'h104,1));
    tbl.push_back(mk(0,0,0, 32'h0,   32'h0,   32'h104, 32'h0,    0,4'h0,32'h0,       0,4'h0,32'h0,    0,0,32'h0,  0));
    // ecall+mret together with a pending csr_req; second ecall while busy is ignored
    tbl.push_back(mk(1,1,1, 32'h200, 32'h400, 32'h0,   32'h0,    1,4'h8,32'h300,     0,4'h0,32'h0,    1,0,32'h0,  0));
    tbl.push_back(mk(1,1,0, 32'h999, 32'h400, 32'h0,   32'h8,    1,4'h8,32'h300,     0,4'h1,32'h200,  1,0,32'h0,  1));
    tbl.push_back(mk(0,0,0, 32'h0,   32'h400, 32'h0,   32'h0,    1,4'h8,32'h300,     0,4'h2,32'd11,   1,0,32'h0,  1));
    tbl.push_back(mk(0,0,0, 32'h0,   32'h400, 32'h0,   32'h0,    1,4'h8,32'h300,     0,4'h4,32'h1800, 1,0,32'h0,  1));
    tbl.push_back(mk(0,0,0, 32'h0,   32'h403, 32'h0,   32'h0,    1,4'h8,32'h300,     0,4'h0,32'h0,    1,1,32'h400,1));
    tbl.push_back(mk(0,0,0, 32'h0,   32'h0,   32'h0,   32'h0,    1,4'h8,32'h300,     1,4'h8,32'h300,  0,0,32'h0,  0));
    tbl.push_back(mk(0,0,0, 32'h0,   32'h0,   32'h0,   32'h0,    0,4'h0,32'h0,       0,4'h0,32'h0,    0,0,32'h0,  0));
    // ecall without ex_valid is ignored; plain CSR grant pass-through
    tbl.push_back(mk(0,1,1, 32'h500, 32'h0,   32'h0,   32'h8,    0,4'h0,32'h0,       0,4'h0,32'h0,    0,0,32'h0,  0));
    tbl.push_back(mk(0,1,0, 32'h500, 32'h0,   32'h0,   32'h8,    1,4'h2,32'hABC,     1,4'h2,32'hABC,  0,0,32'h0,  0));
    tbl.push_back(mk(0,0,0, 32'h0,   32'h0,   32'h0,   32'h0,    0,4'h0,32'h0,       0,4'h0,32'h0,    0,0,32'h0,  0));

    // Reset held, then released with no stimulus for 10 cycles
    drive(idle_v);
    @(negedge clock);
    #1;
    chk_quiet("in_reset", 0);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      #1;
      chk_quiet("post_reset", i);
    end

    for (int i = 0; i < tbl.size(); i++) begin
      run_vec(i, tbl[i]);
    end
`ifdef TRAP_COUNT_EN
    chk("trap_count_two", 0, trap_count, 32'd2);
`endif

    // Reset during T_CAUSE: outputs drop at once, no mstatus write, no redirect
    for (int i = 0; i < 3; i++) begin
      run_vec(100 + i, tbl[i]);
    end
    #2;
    reset = 1'b0;
    #1;
    chk_quiet("mid_reset", 0);
`ifdef TRAP_COUNT_EN
    chk("trap_count_rst", 0, trap_count, 32'd0);
`endif
    drive(idle_v);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      #1;
      chk_quiet("after_abort", i);
    end

    // A full ecall after the aborted one behaves normally
    for (int i = 0; i < 6; i++) begin
      run_vec(200 + i, tbl[i]);
    end
`ifdef TRAP_COUNT_EN
    chk("trap_count_one", 0, trap_count, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
